// File: rtl/prom_fetch_pkg.sv
// Shared types and constants for the boot pROM fetch port.
package prom_fetch_pkg;

    localparam int ROM_ADDR_W = 10;
    localparam int ROM_DATA_W = 32;
    localparam int ROM_BYTES  = 4096;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
    } prom_req_t;

    typedef struct packed {
        logic [ROM_DATA_W-1:0] rdata;
        logic                  err;
    } prom_rsp_t;

    // Byte address to ROM word index for the default-sized macro.
    function automatic logic [ROM_ADDR_W-1:0] word_index(input logic [31:0] addr);
        return addr[ROM_ADDR_W+1:2];
    endfunction

endpackage

// File: rtl/prom_fetch_port.sv
// Two-stage read initiator between the boot-fetch bus and the 1-cycle pROM macro.
// Optional access-fault decode is built when PROM_FETCH_ERR_EN is defined.
module prom_fetch_port
    import prom_fetch_pkg::*;
#(
    parameter int          ADDR_W    = 10,
    parameter int          DATA_W    = 32,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_addr,
    input  logic              req_we,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rom_ce,
    output logic              rom_oce,
    output logic              rom_reset,
    output logic [ADDR_W-1:0] rom_ad,
    input  logic [DATA_W-1:0] rom_dout
);

    localparam logic [31:0] WIN_MASK = 32'((64'd4 << ADDR_W) - 64'd1);

    prom_req_t         req_s;
    logic              fault_s;
    logic              stall_s;
    logic              accept_s;
    logic              s1_valid_r;
    logic              s1_err_r;
    logic              rsp_valid_r;
    logic [DATA_W-1:0] rsp_rdata_r;
    logic              rsp_err_r;

    assign req_s = '{addr: req_addr, we: req_we};

`ifdef PROM_FETCH_ERR_EN
    // Fault decode: writes, misaligned bytes and anything outside the ROM window.
    always_comb begin
        fault_s = 1'b0;
        if (req_s.we || (req_s.addr[1:0] != 2'b00) ||
            ((req_s.addr & ~WIN_MASK) != BASE_ADDR)) begin
            fault_s = 1'b1;
        end else begin
            fault_s = 1'b0;
        end
    end
`else
    logic unused_s;
    assign unused_s = ^{req_s.we, req_s.addr[31:ADDR_W+2], req_s.addr[1:0], WIN_MASK};

    // Without fault decode every request reads; upper and low bits simply alias.
    always_comb begin
        fault_s = 1'b0;
    end
`endif

    // Handshake: the pipe only refuses a request when both stages are held.
    always_comb begin
        stall_s   = rsp_valid_r && !rsp_ready;
        req_ready = !(s1_valid_r && stall_s);
        accept_s  = req_valid && req_ready;
    end

    assign rom_ce    = accept_s && !fault_s;
    assign rom_oce   = 1'b1;
    assign rom_reset = reset;
    assign rom_ad    = req_s.addr[ADDR_W+1:2];

    // S1 tracks the read in flight; ROM dout stays frozen while S1 holds.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_r <= 1'b0;
            s1_err_r   <= 1'b0;
        end else if (accept_s) begin
            s1_valid_r <= 1'b1;
            s1_err_r   <= fault_s;
        end else if (!stall_s) begin
            s1_valid_r <= 1'b0;
        end
    end

    // OUT stage captures ROM data (or the fault) and holds it under backpressure.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= {DATA_W{1'b0}};
            rsp_err_r   <= 1'b0;
        end else if (!stall_s) begin
            rsp_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                rsp_rdata_r <= s1_err_r ? {DATA_W{1'b0}} : rom_dout;
                rsp_err_r   <= s1_err_r;
            end
        end
    end

    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
`ifdef PROM_FETCH_ERR_EN
    assign rsp_err   = rsp_err_r;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_prom_fetch_port.sv
// Scoreboard bench for prom_fetch_port with a behavioural ROM; follows PROM_FETCH_ERR_EN.
module tb_prom_fetch_port;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = 32'h0;
    logic        req_we = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rom_ce;
    logic        rom_oce;
    logic        rom_reset;
    logic [9:0]  rom_ad;
    logic [31:0] rom_dout = 32'h0;

    int n_pass  = 0;
    int n_total = 0;
    logic [32:0] sb[$];
    logic        prev_hold = 1'b0;
    logic [31:0] prev_data = 32'h0;
    logic        prev_err = 1'b0;

    prom_fetch_port #(.ADDR_W(10), .DATA_W(32), .BASE_ADDR(32'h0000_0000)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_we(req_we),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rom_ce(rom_ce), .rom_oce(rom_oce), .rom_reset(rom_reset), .rom_ad(rom_ad),
        .rom_dout(rom_dout)
    );

    always #5 clk = ~clk;

    // Behavioural ROM: word[i] = A500_0000 | i, 1-cycle latency, sync output reset.
    always @(posedge clk) begin
        if (rom_reset) rom_dout <= 32'h0;
        else if (rom_ce) rom_dout <= 32'hA500_0000 | 32'(rom_ad);
    end

    function automatic void check(string name, logic [63:0] got, logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endfunction

    function automatic bit model_fault(logic [31:0] a, logic w);
`ifdef PROM_FETCH_ERR_EN
        return w || (a % 32'd4 != 32'd0) || (a >= 32'd4096);
`else
        return 1'b0;
`endif
    endfunction

    // Expected {err, rdata} for a request, straight from the ROM contents.
    function automatic logic [32:0] model_rsp(logic [31:0] a, logic w);
        if (model_fault(a, w)) return {1'b1, 32'h0};
        return {1'b0, 32'hA500_0000 | ((a / 32'd4) % 32'd1024)};
    endfunction

    // Monitor: request acceptance, ROM strobe, hold stability and response ordering.
    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
            prev_hold = 1'b0;
        end else begin
            logic acc;
            logic [32:0] e;
            check("req_ready", 64'(req_ready), 64'(!(sb.size() == 2 && !rsp_ready)));
            acc = req_valid && req_ready;
            check("rom_ce", 64'(rom_ce), 64'(acc && !model_fault(req_addr, req_we)));
            if (rom_ce) check("rom_ad", 64'(rom_ad), 64'((req_addr / 32'd4) % 32'd1024));
            check("rom_oce", 64'(rom_oce), 64'd1);
            if (prev_hold) begin
                check("hold_valid", 64'(rsp_valid), 64'd1);
                check("hold_data", {31'h0, rsp_err, rsp_rdata}, {31'h0, prev_err, prev_data});
            end
            prev_hold = rsp_valid && !rsp_ready;
            prev_data = rsp_rdata;
            prev_err  = rsp_err;
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    check("spurious_rsp", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("rsp", {31'h0, rsp_err, rsp_rdata}, {31'h0, e});
                end
            end
            if (acc) sb.push_back(model_rsp(req_addr, req_we));
        end
    end

    task automatic send(input logic [31:0] a, input logic w, output int waits);
        req_valid = 1'b1; req_addr = a; req_we = w;
        waits = 0;
        @(negedge clk);
        while (!req_ready && waits < 20) begin
            waits++;
            @(negedge clk);
        end
        if (!req_ready) check("accept_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    initial begin
        int w;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        check("rst_rsp_err", 64'(rsp_err), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd1);

        // Single read with latency check.
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_addr = 32'h10; req_we = 1'b0;
        @(negedge clk);
        check("single_ce", 64'(rom_ce), 64'd1);
        check("single_ad", 64'(rom_ad), 64'd4);
        check("lat_n0", 64'(rsp_valid), 64'd0);
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk);
        check("lat_n1", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        check("lat_n2", 64'(rsp_valid), 64'd1);
        check("single_data", 64'(rsp_rdata), 64'hA500_0004);
        @(posedge clk); #1;

        // Unstalled stream of 8 words.
        for (int i = 0; i < 8; i++) begin
            send(32'(i * 4), 1'b0, w);
            check("stream_ready", 64'(w), 64'd0);
        end
        repeat (3) @(posedge clk); #1;

        // Stream with a 5-cycle response stall in the middle.
        fork
            begin
                for (int i = 0; i < 12; i++) send(32'(32'h40 + i * 4), 1'b0, w);
            end
            begin
                repeat (3) @(posedge clk); #1 rsp_ready = 1'b0;
                repeat (3) @(negedge clk);
                check("bp_ready_low", 64'(req_ready), 64'd0);
                check("bp_ce_low", 64'(rom_ce), 64'd0);
                @(posedge clk); #1;
                repeat (2) @(posedge clk); #1 rsp_ready = 1'b1;
            end
        join
        repeat (3) @(posedge clk); #1;

        // Fault and boundary accesses (expectations follow the build).
        send(32'h4, 1'b1, w);
        send(32'h6, 1'b0, w);
        send(32'h1000, 1'b0, w);
        send(32'hFFC, 1'b0, w);
        send(32'h1004, 1'b0, w);
        repeat (3) @(posedge clk); #1;

        // Reset with S1 and OUT full under backpressure.
        rsp_ready = 1'b0;
        send(32'h20, 1'b0, w);
        send(32'h24, 1'b0, w);
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        check("async_rst_valid", 64'(rsp_valid), 64'd0);
        check("async_rst_ready", 64'(req_ready), 64'd1);
        @(posedge clk); #1 reset = 1'b0;
        rsp_ready = 1'b1;
        send(32'h30, 1'b0, w);
        @(negedge clk);
        check("post_rst_idle", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        check("post_rst_valid", 64'(rsp_valid), 64'd1);
        check("post_rst_data", 64'(rsp_rdata), 64'hA500_000C);
        @(posedge clk); #1;

        // Randomised traffic.
        for (int c = 0; c < 600; c++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            req_we    = ($urandom_range(0, 15) == 0);
            rsp_ready = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 7))
                0: req_addr = $urandom;
                1: req_addr = 32'($urandom_range(0, 4095));
                2: req_addr = ($urandom_range(0, 1) != 0) ? 32'hFFC : 32'h1000;
                default: req_addr = 32'($urandom_range(0, 1023)) << 2;
            endcase
            @(posedge clk); #1;
        end

        // Drain.
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 20 && sb.size() != 0; c++) @(posedge clk);
        @(negedge clk);
        check("drain_empty", 64'(sb.size()), 64'd0);
        check("drain_idle", 64'(rsp_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
